multi_cycle_mips_core: RTL and testbench
========================================

// Module: multi_cycle_mips_core
// PURPOSE
//  Multi-cycle successor to the team's single-cycle MIPS datapath: same ISA subset plus bne/halt,
//  executed by an FSM over one shared ALU. Memory depths and reset PC are parametrised.
//  Adds a program-load port, run/halt control, illegal/misaligned trapping and a debug register
//  read port. Sits at top level under the test harness; instruction and data memories are internal.
// PARAMETERS
//  IMEM_BYTES  256  instruction memory size in bytes (power of 2, >=16); byte addr = pc mod IMEM_BYTES
//  DMEM_BYTES  256  data memory size in bytes (power of 2, >=16); byte addr = ALU result mod DMEM_BYTES
//  RESET_PC    0    PC value loaded on reset and on each start pulse (word aligned)
// PORTS
//  clk        in   1   clock, all state changes on rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   1-cycle pulse; accepted only in IDLE or HALT: pc<=RESET_PC, state->FETCH
//  load_we    in   1   program-load write; accepted only in IDLE/HALT, ignored otherwise
//  load_addr  in   32  imem byte address, word aligned ([1:0] ignored), wraps mod IMEM_BYTES
//  load_data  in   32  instruction word, stored little-endian (byte0 = [7:0])
//  dbg_addr   in   5   debug register index
//  dbg_rdata  out  32  registers[dbg_addr], combinational, reg 0 reads 0
//  pc_out     out  32  current PC register
//  busy       out  1   1 in FETCH/DECODE/EXEC/MEM/WB
//  halted     out  1   1 in HALT
//  trap       out  1   sticky: last halt caused by illegal opcode/funct or misaligned lw/sw
//  retire     out  1   1-cycle pulse in the cycle an instruction completes (incl. halt)
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 regs=0, busy=halted=trap=retire=0.
//   Memories are not reset. Reset mid-instruction aborts it; no partial reg/mem write may survive.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//   FETCH:  IR<=imem[pc]; pc<=pc+4 (32-bit wrap).
//   DECODE: A<=rs, B<=rt, sext(imm16) latched; halt opcode 6'b111111 -> HALT (retire, trap=0);
//           unknown opcode/funct -> HALT (retire, trap=1).
//   EXEC:   ALUOut computed. beq/bne: if taken pc<=pc+(sext(imm)<<2) (pc already +4); j:
//           pc<={pc[31:28],imm26,2'b00}; branches/jumps retire here -> FETCH.
//           lw/sw with ALUOut[1:0]!=0 -> HALT, trap=1, no access. lw/sw -> MEM; others -> WB.
//   MEM:    sw writes 4 bytes little-endian, retire -> FETCH; lw MDR<=dmem word -> WB.
//   WB:     rd (R-type) or rt (I-type) <= ALUOut or MDR; writes to reg 0 discarded; retire -> FETCH.
//  Latency per instruction: j/beq/bne 3, R-type/addi/addiu/lui/slti/sw 4, lw 5, halt/illegal 2.
//  ALU (32-bit, overflow ignored, no exceptions): add/addi/addiu = A+B or A+sext(imm); sub A-B;
//   and, or; slt/slti signed compare -> 0/1; sll rd = rt << shamt[10:6]; lui rt = {imm16,16'h0}.
//   addiu uses sign-extended imm (MIPS semantics).
//  Register write and data-memory write happen only on the clock edge leaving WB/MEM respectively.
//  start while busy: ignored. start and load_we same cycle in IDLE: both take effect, load first.
//  load_we while busy: ignored, imem unchanged. trap cleared on start.
//  Reading imem/dmem at top of range wraps byte-wise (addr+3 mod size).
// TESTING
//  1 Reset mid-EXEC of addi $1,$0,5 -> IDLE, $1=0, pc=RESET_PC, busy=0, no retire.
//  2 Load {addi $1,$0,100; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sll $5,$1,2; halt}, start
//    -> $3=97, $4=1, $5=400, halted=1, trap=0, 6 retire pulses, 4+4+4+4+4+2=22 busy cycles.
//  3 sw $1,8($0) then lw $6,8($0), $1=32'hDEADBEEF -> dmem[8..11]=EF,BE,AD,DE; $6=DEADBEEF; lw 5 cycles.
//  4 beq taken (offset -2) loops back; bne not taken falls to pc+4; j 0x10 -> pc=0x40; 3 cycles each.
//  5 lw $1,2($0) -> HALT, trap=1, $1 unchanged; start -> trap=0, restarts at RESET_PC.
//  6 Opcode 6'b010000 -> HALT trap=1 after 2 cycles; load_we during busy ignored; add $0 keeps $0=0.

Source files
------------

// File: rtl/multi_cycle_mips_core.sv
// Multi-cycle MIPS subset core: one shared ALU sequenced by an FSM, internal byte-wide
// instruction/data memories, a program-load port, run/halt control, trapping and a debug register read.
module multi_cycle_mips_core #(
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned DMEM_BYTES = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_rdata,
    output logic [31:0] pc_out,
    output logic        busy,
    output logic        halted,
    output logic        trap,
    output logic        retire
);
    localparam int unsigned IAW = $clog2(IMEM_BYTES);
    localparam int unsigned DAW = $clog2(DMEM_BYTES);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2a;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic        trap_q, retire_q;
    logic [31:0] regs_q [32];
    logic [7:0]  imem_q [IMEM_BYTES];
    logic [7:0]  dmem_q [DMEM_BYTES];

    logic [5:0]     op, funct;
    logic [4:0]     rs, rt, rd, shamt, dest_c;
    logic [31:0]    alu_c, imem_word_c, dmem_word_c, wb_data_c;
    logic           legal_c, ctl_idle_c;
    logic [IAW-1:0] ia_c, la_c;
    logic [DAW-1:0] da_c;
    logic           unused_c;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];

    assign dest_c     = (op == OP_R) ? rd : rt;
    assign wb_data_c  = (op == OP_LW) ? mdr_q : alu_q;
    assign ctl_idle_c = (state_q == S_IDLE) || (state_q == S_HALT);

    assign ia_c = pc_q[IAW-1:0];
    assign la_c = {load_addr[IAW-1:2], 2'b00};
    assign da_c = alu_q[DAW-1:0];
    assign unused_c = ^{load_addr[31:IAW], load_addr[1:0]};

    // Little-endian word reads; byte addresses wrap at the top of each memory
    assign imem_word_c = {imem_q[ia_c + IAW'(3)], imem_q[ia_c + IAW'(2)],
                          imem_q[ia_c + IAW'(1)], imem_q[ia_c]};
    assign dmem_word_c = {dmem_q[da_c + DAW'(3)], dmem_q[da_c + DAW'(2)],
                          dmem_q[da_c + DAW'(1)], dmem_q[da_c]};

    always_comb begin
        legal_c = 1'b0;
        case (op)
            OP_R: legal_c = (funct == F_SLL) || (funct == F_ADD) || (funct == F_SUB) ||
                            (funct == F_AND) || (funct == F_OR)  || (funct == F_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_LUI, OP_LW, OP_SW, OP_HALT: legal_c = 1'b1;
            default: legal_c = 1'b0;
        endcase
    end

    // Shared ALU; branches use the difference for their equality test
    always_comb begin
        alu_c = '0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADD:   alu_c = a_q + b_q;
                    F_SUB:   alu_c = a_q - b_q;
                    F_AND:   alu_c = a_q & b_q;
                    F_OR:    alu_c = a_q | b_q;
                    F_SLT:   alu_c = {31'b0, $signed(a_q) < $signed(b_q)};
                    F_SLL:   alu_c = b_q << shamt;
                    default: alu_c = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_c = a_q + imm_q;
            OP_SLTI:         alu_c = {31'b0, $signed(a_q) < $signed(imm_q)};
            OP_LUI:          alu_c = {ir_q[15:0], 16'h0000};
            OP_BEQ, OP_BNE:  alu_c = a_q - b_q;
            default:         alu_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            trap_q   <= 1'b0;
            retire_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc_q    <= RESET_PC;
                        trap_q  <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_q    <= imem_word_c;
                    pc_q    <= pc_q + 32'd4;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q   <= regs_q[rs];
                    b_q   <= regs_q[rt];
                    imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
                    if (op == OP_HALT || !legal_c) begin
                        trap_q   <= (op != OP_HALT);
                        retire_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_c;
                    case (op)
                        OP_BEQ, OP_BNE: begin
                            if ((alu_c == 32'd0) == (op == OP_BEQ))
                                pc_q <= pc_q + {imm_q[29:0], 2'b00};
                            retire_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                        OP_J: begin
                            pc_q     <= {pc_q[31:28], ir_q[25:0], 2'b00};
                            retire_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            if (alu_c[1:0] != 2'b00) begin
                                trap_q  <= 1'b1;
                                state_q <= S_HALT;
                            end else begin
                                state_q <= S_MEM;
                            end
                        end
                        default: state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (op == OP_SW) begin
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else begin
                        mdr_q   <= dmem_word_c;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (dest_c != 5'd0) regs_q[dest_c] <= wb_data_c;
                    retire_q <= 1'b1;
                    state_q  <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Program load is only honoured while the core is stopped
    always_ff @(posedge clk) begin
        if (load_we && ctl_idle_c) begin
            imem_q[la_c]           <= load_data[7:0];
            imem_q[la_c + IAW'(1)] <= load_data[15:8];
            imem_q[la_c + IAW'(2)] <= load_data[23:16];
            imem_q[la_c + IAW'(3)] <= load_data[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_MEM && op == OP_SW) begin
            dmem_q[da_c]           <= b_q[7:0];
            dmem_q[da_c + DAW'(1)] <= b_q[15:8];
            dmem_q[da_c + DAW'(2)] <= b_q[23:16];
            dmem_q[da_c + DAW'(3)] <= b_q[31:24];
        end
    end

    assign dbg_rdata = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];
    assign pc_out    = pc_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM)   || (state_q == S_WB);
    assign halted    = (state_q == S_HALT);
    assign trap      = trap_q;
    assign retire    = retire_q;

endmodule

// File: tb/tb_multi_cycle_mips_core.sv
// Directed bench for multi_cycle_mips_core: hand-assembled programs with hand-computed
// register results, busy-cycle counts and retire counts.
module tb_multi_cycle_mips_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata, pc_out;
    logic        busy, halted, trap, retire;

    int checks = 0;
    int errors = 0;
    int bcyc, rets;

    localparam logic [31:0] W_HALT = 32'hFC00_0000;

    multi_cycle_mips_core #(.IMEM_BYTES(256), .DMEM_BYTES(256), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .pc_out(pc_out),
        .busy(busy), .halted(halted), .trap(trap), .retire(retire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        load_we = 1'b1; load_addr = addr; load_data = data;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle load); returns at the first FETCH cycle
    task automatic start_run(input bit with_load, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        start = 1'b1;
        load_we = with_load; load_addr = addr; load_data = data;
        @(negedge clk);
        start = 1'b0; load_we = 1'b0;
    endtask

    // Counts busy cycles and retire pulses until HALT; optional poke issues load+start while busy
    task automatic run_prog(input int budget, input bit poke, output int bc, output int rc);
        bit done = 1'b0;
        bc = 0; rc = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (busy) bc++;
            if (retire) rc++;
            if (halted) begin
                done = 1'b1;
            end else begin
                if (poke && i == 2) begin
                    load_we = 1'b1; load_addr = 32'h8; load_data = W_HALT; start = 1'b1;
                end else begin
                    load_we = 1'b0; start = 1'b0;
                end
                @(negedge clk);
            end
        end
        load_we = 1'b0; start = 1'b0;
        chk("halt_reached", {31'b0, halted}, 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy",   {31'b0, busy},   32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_trap",   {31'b0, trap},   32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_pc",     pc_out,          32'd0);
        @(negedge clk) rst = 1'b0;

        // 1: reset while addi $1,$0,5 is in EXEC
        load_word(32'h0, 32'h2001_0005);
        load_word(32'h4, W_HALT);
        start_run(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy_exec", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_busy",   {31'b0, busy},   32'd0);
        chk("t1_pc",     pc_out,          32'd0);
        chk("t1_retire", {31'b0, retire}, 32'd0);
        chk_reg("t1_r1", 5'd1, 32'd0);
        @(negedge clk) rst = 1'b0;
        rets = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (retire) rets++;
        end
        chk("t1_no_retire", rets, 32'd0);
        chk("t1_idle",      {31'b0, busy}, 32'd0);
        chk_reg("t1_r1_after", 5'd1, 32'd0);

        // 2: ALU program; halt word loaded in the same cycle as start
        do_reset();
        load_word(32'h00, 32'h2001_0064);
        load_word(32'h04, 32'h2002_FFFD);
        load_word(32'h08, 32'h0022_1820);
        load_word(32'h0C, 32'h0041_202A);
        load_word(32'h10, 32'h0001_2880);
        start_run(1'b1, 32'h14, W_HALT);
        run_prog(200, 1'b0, bcyc, rets);
        chk("t2_busy",   bcyc, 32'd22);
        chk("t2_retire", rets, 32'd6);
        chk("t2_trap",   {31'b0, trap}, 32'd0);
        chk("t2_pc",     pc_out, 32'h18);
        chk_reg("t2_r2", 5'd2, 32'hFFFF_FFFD);
        chk_reg("t2_r3", 5'd3, 32'd97);
        chk_reg("t2_r4", 5'd4, 32'd1);
        chk_reg("t2_r5", 5'd5, 32'd400);

        // 3: sw/lw round trip of 0xDEADBEEF
        do_reset();
        load_word(32'h00, 32'h3C01_DEAE);
        load_word(32'h04, 32'h2021_BEEF);
        load_word(32'h08, 32'hAC01_0008);
        load_word(32'h0C, 32'h8C06_0008);
        load_word(32'h10, W_HALT);
        start_run(1'b0, 32'h0, 32'h0);
        run_prog(200, 1'b0, bcyc, rets);
        chk("t3_busy",   bcyc, 32'd19);
        chk("t3_retire", rets, 32'd5);
        chk_reg("t3_r1", 5'd1, 32'hDEAD_BEEF);
        chk_reg("t3_r6", 5'd6, 32'hDEAD_BEEF);
        chk("t3_dmem8",  {24'h0, dut.dmem_q[8]},  32'hEF);
        chk("t3_dmem9",  {24'h0, dut.dmem_q[9]},  32'hBE);
        chk("t3_dmem10", {24'h0, dut.dmem_q[10]}, 32'hAD);
        chk("t3_dmem11", {24'h0, dut.dmem_q[11]}, 32'hDE);

        // 4: beq taken back, beq/bne not taken, j to 0x40; word 0 loaded via aliased address
        do_reset();
        load_word(32'h100, 32'h2001_0001);
        load_word(32'h04,  32'h2042_0001);
        load_word(32'h08,  32'h1041_FFFE);
        load_word(32'h0C,  32'h1421_0005);
        load_word(32'h10,  32'h0800_0010);
        load_word(32'h40,  W_HALT);
        start_run(1'b0, 32'h0, 32'h0);
        run_prog(300, 1'b0, bcyc, rets);
        chk("t4_busy",   bcyc, 32'd26);
        chk("t4_retire", rets, 32'd8);
        chk("t4_pc",     pc_out, 32'h44);
        chk("t4_trap",   {31'b0, trap}, 32'd0);
        chk_reg("t4_r1", 5'd1, 32'd1);
        chk_reg("t4_r2", 5'd2, 32'd2);

        // 5: misaligned lw traps; start clears trap and restarts at 0
        do_reset();
        load_word(32'h00, 32'h2001_0007);
        load_word(32'h04, 32'h8C01_0002);
        load_word(32'h08, W_HALT);
        start_run(1'b0, 32'h0, 32'h0);
        run_prog(200, 1'b0, bcyc, rets);
        chk("t5_busy",   bcyc, 32'd7);
        chk("t5_retire", rets, 32'd1);
        chk("t5_trap",   {31'b0, trap}, 32'd1);
        chk("t5_pc",     pc_out, 32'h08);
        chk_reg("t5_r1", 5'd1, 32'd7);
        start_run(1'b0, 32'h0, 32'h0);
        chk("t5_trap_clr", {31'b0, trap}, 32'd0);
        chk("t5_restart_pc", pc_out, 32'd0);
        chk("t5_restart_busy", {31'b0, busy}, 32'd1);
        run_prog(200, 1'b0, bcyc, rets);
        chk("t5_busy2", bcyc, 32'd7);
        chk("t5_trap2", {31'b0, trap}, 32'd1);

        // 6: illegal opcode; load_we and start while busy ignored; add to $0 discarded
        do_reset();
        load_word(32'h00, 32'h2001_0009);
        load_word(32'h04, 32'h0021_0020);
        load_word(32'h08, 32'h4000_0000);
        start_run(1'b0, 32'h0, 32'h0);
        run_prog(200, 1'b1, bcyc, rets);
        chk("t6_busy",   bcyc, 32'd10);
        chk("t6_retire", rets, 32'd3);
        chk("t6_trap",   {31'b0, trap}, 32'd1);
        chk("t6_pc",     pc_out, 32'h0C);
        chk_reg("t6_r0", 5'd0, 32'd0);
        chk_reg("t6_r1", 5'd1, 32'd9);

        // 7: addiu / slti / sub / and / or
        do_reset();
        load_word(32'h00, 32'h2407_FFFF);
        load_word(32'h04, 32'h28E8_0000);
        load_word(32'h08, 32'h0107_4822);
        load_word(32'h0C, 32'h00E9_5024);
        load_word(32'h10, 32'h0109_5825);
        load_word(32'h14, W_HALT);
        start_run(1'b0, 32'h0, 32'h0);
        run_prog(200, 1'b0, bcyc, rets);
        chk("t7_busy", bcyc, 32'd22);
        chk_reg("t7_r7",  5'd7,  32'hFFFF_FFFF);
        chk_reg("t7_r8",  5'd8,  32'd1);
        chk_reg("t7_r9",  5'd9,  32'd2);
        chk_reg("t7_r10", 5'd10, 32'd2);
        chk_reg("t7_r11", 5'd11, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
